// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the combinational ROM and
// buffers {pc, instr} pairs in a small FIFO toward decode, with redirect/flush.
module instr_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic        rom_en_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        err_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  ent_t          mem_q [FIFO_DEPTH];
  ent_t          head_q, head_nxt, push_ent;
  logic          redir, bad_redir, ok_redir, pop, fetch;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ERR swallows every redirect; otherwise alignment decides flush-and-jump vs. error
  assign redir     = redirect_i && (state_q != ERR);
  assign bad_redir = redir && (redirect_pc_i[1:0] != 2'b00);
  assign ok_redir  = redir && !bad_redir;

  assign instr_valid_o = (state_q != ERR) && (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign fetch         = (state_q == RUN) && !redirect_i && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign push_ent      = '{pc: pc_q, instr: rom_instr_i};

  assign rom_en_o   = fetch;
  assign rom_addr_o = pc_q;
  assign instr_o    = head_q.instr;
  assign instr_pc_o = head_q.pc;
  assign err_o      = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en_i) state_d = RUN;
      RUN:     if (!fetch_en_i) state_d = IDLE;
      default: state_d = ERR;
    endcase
    if (bad_redir) state_d = ERR;
  end

  always_comb begin
    rd_d    = pop ? ptr_inc(rd_q) : rd_q;
    wr_d    = fetch ? ptr_inc(wr_q) : wr_q;
    count_d = count_q + CW'(fetch) - CW'(pop);
    if (redir) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
  end

  // When the FIFO drains to empty this cycle, the new head is the word being fetched now
  assign head_nxt = (count_q == CW'(pop)) ? push_ent : mem_q[rd_d];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (ok_redir)   pc_q <= redirect_pc_i;
      else if (fetch) pc_q <= pc_q + 32'd4;
      if (!redir && (count_d != '0)) head_q <= head_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fetch) mem_q[wr_q] <= push_ent;
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl: queue-based reference model predicts
// deliveries into a scoreboard that a negedge monitor drains.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk_i, rst_ni, fetch_en_i, rom_en_o, redirect_i;
  logic        instr_valid_o, instr_ready_i, err_o;
  logic [31:0] rom_addr_o, rom_instr_i, redirect_pc_i, instr_o, instr_pc_o;

  instr_fetch_ctrl #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_instr_i(rom_instr_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int   total = 0, bad = 0;
  ent_t mq[$];   // model fetch buffer, oldest first
  ent_t sb[$];   // expected deliveries
  ent_t m_hold;
  logic [31:0] m_pc;
  int   m_mode;  // 0 idle, 1 run, 2 error

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h1357_0000;
  endfunction

  assign rom_instr_i = rom_en_o ? rom_fn(rom_addr_o) : 32'hDEAD_BEEF;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_pc   = BOOT;
    m_mode = 0;
    m_hold = '0;
  endtask

  // Called at posedge+1: drive one cycle of inputs, check, advance the model.
  task automatic cyc(input logic en, input logic rdy, input logic rd, input logic [31:0] tgt);
    bit   v, p, f;
    ent_t e;
    fetch_en_i = en; instr_ready_i = rdy; redirect_i = rd; redirect_pc_i = tgt;
    #1;
    v = (mq.size() > 0);
    p = v && rdy;
    f = (m_mode == 1) && !rd && ((mq.size() < DEPTH) || p);
    if (v) m_hold = mq[0];
    chk("rom_en", {31'b0, rom_en_o}, {31'b0, f});
    chk("rom_addr", rom_addr_o, m_pc);
    chk("valid", {31'b0, instr_valid_o}, {31'b0, v});
    chk("err", {31'b0, err_o}, {31'b0, m_mode == 2});
    chk("head_pc", instr_pc_o, m_hold.pc);
    chk("head_instr", instr_o, m_hold.ins);
    if (m_mode != 2 && rd) begin
      mq.delete();
      if (tgt[1:0] != 2'b00) m_mode = 2;
      else m_pc = tgt;
    end else begin
      if (p) begin
        sb.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (f) begin
        e.pc = m_pc; e.ins = rom_fn(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_mode == 0 && en) m_mode = 1;
    else if (m_mode == 1 && !en) m_mode = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic rand_cyc(input bit allow_bad);
    logic        en, rdy, rd;
    logic [31:0] tgt;
    en  = ($urandom_range(0, 9) != 0);
    rdy = ($urandom_range(0, 2) != 0);
    rd  = ($urandom_range(0, 14) == 0);
    tgt = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    if (allow_bad) tgt[1:0] = 2'($urandom_range(0, 3));
    cyc(en, rdy, rd, tgt);
  endtask

  // Asynchronous reset in the middle of a cycle, released at the next posedge+1.
  task automatic mid_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_rom_en", {31'b0, rom_en_o}, 32'd0);
    chk("rst_addr", rom_addr_o, BOOT);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_head_pc", instr_pc_o, 32'd0);
    chk("rst_head_instr", instr_o, 32'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  always @(negedge clk_i) begin
    ent_t e;
    if (rst_ni && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL deliver: got pc %h, none expected", instr_pc_o);
      end else begin
        e = sb.pop_front();
        chk("deliver_pc", instr_pc_o, e.pc);
        chk("deliver_instr", instr_o, e.ins);
      end
    end
  end

  initial begin
    rst_ni = 1'b0; fetch_en_i = 1'b1; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    model_reset();
    #12;
    chk("reset_rom_en", {31'b0, rom_en_o}, 32'd0);
    chk("reset_addr", rom_addr_o, BOOT);
    chk("reset_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("reset_instr", instr_o, 32'd0);
    chk("reset_pc", instr_pc_o, 32'd0);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    repeat (6) cyc(1'b1, 1'b1, 1'b0, '0);               // start-up stream
    cyc(1'b1, 1'b0, 1'b1, 32'h0);                       // restart at 0 under backpressure
    repeat (5) cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);               // fill, then redirect full FIFO
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 32'h100);                     // redirect while popping
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);               // wrap-around
    repeat (4) cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);               // drain with fetch disabled
    cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);

    repeat (400) rand_cyc(1'b0);

    mid_reset();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, '0);

    repeat (2) cyc(1'b1, 1'b0, 1'b0, '0);               // misaligned redirect -> sticky error
    cyc(1'b1, 1'b1, 1'b1, 32'h42);
    cyc(1'b1, 1'b1, 1'b1, 32'h80);
    repeat (30) rand_cyc(1'b1);

    mid_reset();
    repeat (300) rand_cyc(1'b0);
    repeat (60) rand_cyc(1'b1);
    mid_reset();
    repeat (8) cyc(1'b1, 1'b1, 1'b0, '0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller that sequences the core's combinational instruction ROM. It owns the program counter, drives the ROM enable and address, and buffers fetched words with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake and handles control-flow redirects, flushing stale fetches. It sits between the instruction ROM and the decode stage.

## Interface
- BOOT_ADDR, 32'h0000_0000, PC loaded at reset; must be word-aligned
- FIFO_DEPTH, 2, fetch-buffer entries; legal values 2..8
- clk_i  input  1  core clock; all state updates on the rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- fetch_en_i  input  1  fetch permission from the core controller
- rom_en_o  output  1  ROM read enable
- rom_addr_o  output  32  ROM byte address; equals pc_q
- rom_instr_i  input  32  ROM read data, valid in the same cycle as rom_en_o
- redirect_i  input  1  one-cycle pulse; load a new PC and flush
- redirect_pc_i  input  32  redirect target, byte address
- instr_valid_o  output  1  FIFO head is valid
- instr_o  output  32  instruction at the FIFO head
- instr_pc_o  output  32  PC of the instruction at the FIFO head
- instr_ready_i  input  1  decode accepts the head this cycle
- err_o  output  1  sticky: a misaligned redirect was received

## Operation
- FSM states: IDLE, RUN, ERR. Reset state is IDLE.
  - IDLE -> RUN when fetch_en_i=1.
  - RUN -> IDLE when fetch_en_i=0.
  - Any state -> ERR when redirect_i=1 and redirect_pc_i[1:0]!=0.
  - ERR is left only by reset.
- Fetch condition, evaluated in RUN only: fetch = !redirect_i && (count<FIFO_DEPTH || pop).
- pop = instr_valid_o && instr_ready_i.
- rom_en_o = fetch. rom_addr_o = pc_q at all times.
- On fetch: push {pc_q, rom_instr_i} into the FIFO; pc_q <= pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Aligned redirect, in any state except ERR:
  - pc_q <= redirect_pc_i.
  - All FIFO entries are discarded, including any entry popped in that same cycle.
  - No fetch occurs in the redirect cycle.
- Redirect has priority over pop and push.
- Misaligned redirect:
  - FIFO flushed, err_o <= 1, state <= ERR.
  - pc_q is unchanged.
- ERR: rom_en_o=0 and instr_valid_o=0. All further redirects, fetch_en_i and instr_ready_i are ignored.
- IDLE: no fetches, and pc_q is held. Existing FIFO entries remain poppable, so decode can drain.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Entries leave the FIFO in strict fetch order. No entry is duplicated or lost except by flush.

## Timing
- Reset values:
  - State IDLE, pc_q=BOOT_ADDR, count=0.
  - rom_en_o=0, rom_addr_o=BOOT_ADDR.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, err_o=0.
- Start-up: fetch_en_i sampled high at edge E, so the FSM is in RUN after E.
  - Cycle after E: rom_en_o=1, rom_addr_o=BOOT_ADDR.
  - instr_valid_o=1 after edge E+1.
- Latency is 1 cycle from ROM read to instr_valid_o.
- Sustained throughput is 1 instruction/cycle while instr_ready_i=1.
- Redirect sampled at edge R:
  - instr_valid_o=0 after R.
  - First fetch at redirect_pc_i occurs in the cycle after R; its instruction is valid after R+1.
- instr_o and instr_pc_o are registered FIFO outputs: stable while instr_valid_o=1 and instr_ready_i=0.
- With instr_valid_o=0, instr_o and instr_pc_o hold their last value; they are 0 after reset.
- Reset asserted mid-operation: all state returns to its reset values immediately and asynchronously. Fetching restarts from BOOT_ADDR only after rst_ni is released and fetch_en_i is seen high.

## Test plan
- Reset and start: assert rst_ni=0 with fetch_en_i=1, then release -> outputs at reset values. Then, with ready=1, instr_pc_o takes 0x0, 0x4, 0x8, 0xC on consecutive cycles, and instr_o matches ROM words 0..3.
- Backpressure: hold ready=0 for 5 cycles after start -> FIFO holds PCs 0x0 and 0x4, and rom_en_o drops to 0 once full. Release ready -> PCs 0x0, 0x4, 0x8 delivered in order with no gaps or duplicates.
- Redirect with full FIFO: pulse redirect_i with target 0x40 -> instr_valid_o=0 for one cycle, and the next delivered PC is 0x40 followed by 0x44. Entries 0x0 and 0x4 are never delivered.
- Misaligned redirect: target 0x42 -> err_o=1 on the next cycle, then instr_valid_o=0 and rom_en_o=0 permanently. A later aligned redirect to 0x80 has no effect.
- Wrap-around: BOOT_ADDR=32'hFFFF_FFF8 -> delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Drain and reset mid-run: drop fetch_en_i with 2 entries buffered -> both entries are still delivered and rom_en_o=0. Then assert rst_ni mid-cycle -> instr_valid_o=0 immediately, and pc restarts at BOOT_ADDR.
